// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared mode encodings and signed range helpers for the accumulating ALU
package alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_SUB    = 2'b01,
    MODE_SATADD = 2'b10,
    MODE_ACC    = 2'b11
  } mode_e;

  function automatic longint signed_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint signed_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/param_alu_acc_if.sv
// rtl/param_alu_acc_if.sv - operand/result handshake bundle for param_alu_acc
interface param_alu_acc_if #(
  parameter int W  = 4,
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    mode;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          ovf;
  logic [CW-1:0] acc_count;

  modport master (
    output in_valid, a, b, mode, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, acc_count
  );

  modport slave (
    input  in_valid, a, b, mode, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, acc_count
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational wrap/sub/saturating add datapath with carry and overflow flags
module alu_core
  import alu_pkg::*;
#(
  parameter int W      = 4,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  mode_e        mode,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         ovf
);
  localparam bit           IS_SIGNED = (SIGNED != 0);
  localparam logic [W-1:0] SMAX      = W'(signed_max(W));
  localparam logic [W-1:0] SMIN      = W'(signed_min(W));

  logic [W:0] sum;
  logic [W:0] diff;
  logic       add_ovf;
  logic       sub_ovf;

  assign sum  = {1'b0, x} + {1'b0, y};
  assign diff = {1'b0, x} - {1'b0, y};

  // Signed overflow: result sign disagrees with what the operand signs allow
  assign add_ovf = IS_SIGNED ? ((x[W-1] == y[W-1]) && (sum[W-1] != x[W-1])) : sum[W];
  assign sub_ovf = IS_SIGNED ? ((x[W-1] != y[W-1]) && (diff[W-1] != x[W-1])) : diff[W];

  always_comb begin
    res   = sum[W-1:0];
    carry = sum[W];
    ovf   = add_ovf;
    case (mode)
      MODE_SUB: begin
        res   = diff[W-1:0];
        carry = diff[W];
        ovf   = sub_ovf;
      end
      MODE_SATADD: begin
        carry = 1'b0;
        if (add_ovf) begin
          if (IS_SIGNED) res = x[W-1] ? SMIN : SMAX;
          else           res = '1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/param_alu_acc.sv
// rtl/param_alu_acc.sv - registered ALU with accumulator, transaction counter and valid/ready handshake
module param_alu_acc
  import alu_pkg::*;
#(
  parameter int W      = 4,
  parameter int SIGNED = 0,
  parameter int CW     = 4
) (
  input logic           clk,
  input logic           rst_n,
  param_alu_acc_if.slave bus
);
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          consume;
  logic          is_acc;
  logic [W-1:0]  y_op;
  logic [CW-1:0] cnt_base;
  logic [W-1:0]  core_res;
  logic          core_carry;
  logic          core_ovf;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc_count = cnt_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign consume  = out_valid_q && bus.out_ready;
  assign is_acc   = (mode_e'(bus.mode) == MODE_ACC);
  // A clear coincident with an ACC takes effect before the add
  assign y_op     = is_acc ? (bus.acc_clr ? '0 : acc_q) : bus.b;
  assign cnt_base = bus.acc_clr ? '0 : cnt_q;

  alu_core #(.W(W), .SIGNED(SIGNED)) u_core (
    .x     (bus.a),
    .y     (y_op),
    .mode  (mode_e'(bus.mode)),
    .res   (core_res),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    acc_d       = bus.acc_clr ? '0 : acc_q;
    cnt_d       = cnt_base;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_res;
      carry_d     = core_carry;
      ovf_d       = core_ovf;
      if (is_acc) begin
        acc_d = core_res;
        cnt_d = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
